// File: rtl/conbus_arbn_pkg.sv
// Shared constants and helpers for the conbus round-robin arbiter family.
package conbus_arbn_pkg;

  localparam int unsigned NMASTERS_MIN = 2;
  localparam int unsigned NMASTERS_MAX = 16;
  localparam int unsigned MAXHOLD_MAX  = 255;
  localparam int unsigned HOLDW        = 8;

  typedef logic [HOLDW-1:0] hold_cnt_t;

  function automatic int unsigned conbus_idxw(input int unsigned n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/conbus_arbn_pick.sv
// Rotating find-first: first requester strictly after cur, wrapping modulo NMASTERS.
module conbus_arbn_pick
  import conbus_arbn_pkg::*;
#(
  parameter  int unsigned NMASTERS = 6,
  localparam int unsigned IDXW     = conbus_idxw(NMASTERS)
) (
  input  logic [NMASTERS-1:0] req,
  input  logic [IDXW-1:0]     cur,
  output logic                found,
  output logic [IDXW-1:0]     next_idx
);

  int unsigned     pos;
  logic [IDXW-1:0] pos_idx;

  always_comb begin
    found    = 1'b0;
    next_idx = cur;
    pos      = 0;
    pos_idx  = '0;
    // cur itself is excluded; the caller decides what happens when only cur requests
    for (int unsigned k = 1; k < NMASTERS; k++) begin
      pos     = (int'(cur) + k) % NMASTERS;
      pos_idx = IDXW'(pos);
      if (!found && req[pos_idx]) begin
        found    = 1'b1;
        next_idx = pos_idx;
      end
    end
  end

endmodule

// File: rtl/conbus_arbn.sv
// N-master round-robin bus arbiter with optional hold limit, lock and preempt pulse.
module conbus_arbn
  import conbus_arbn_pkg::*;
#(
  parameter  int unsigned NMASTERS = 6,
  parameter  int unsigned MAXHOLD  = 0,
  localparam int unsigned IDXW     = conbus_idxw(NMASTERS)
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic [NMASTERS-1:0] req,
  input  logic [NMASTERS-1:0] lock,
  output logic [NMASTERS-1:0] gnt,
  output logic [IDXW-1:0]     gnt_idx,
  output logic                preempt
);

  localparam hold_cnt_t HOLD_SAT = (MAXHOLD > 0) ? HOLDW'(MAXHOLD - 1) : '0;

  if (NMASTERS < NMASTERS_MIN || NMASTERS > NMASTERS_MAX) begin : g_bad_nmasters
    $error("conbus_arbn: NMASTERS out of range");
  end
  if (MAXHOLD > MAXHOLD_MAX) begin : g_bad_maxhold
    $error("conbus_arbn: MAXHOLD out of range");
  end

  logic [IDXW-1:0]     cur_q, cur_d;
  hold_cnt_t           hold_q, hold_d;
  logic                preempt_q, preempt_d;
  logic [NMASTERS-1:0] gnt_q, gnt_d;
  logic                found;
  logic [IDXW-1:0]     next_idx;
  logic                hold_sat;

  conbus_arbn_pick #(
    .NMASTERS (NMASTERS)
  ) u_pick (
    .req      (req),
    .cur      (cur_q),
    .found    (found),
    .next_idx (next_idx)
  );

  always_comb begin
    cur_d     = cur_q;
    hold_d    = hold_q;
    preempt_d = 1'b0;
    hold_sat  = (MAXHOLD != 0) && (hold_q == HOLD_SAT);
    if (req[cur_q]) begin
      if (hold_sat && !lock[cur_q] && found) begin
        cur_d     = next_idx;
        hold_d    = '0;
        preempt_d = 1'b1;
      end else if ((MAXHOLD != 0) && !hold_sat) begin
        hold_d = hold_q + 1'b1;
      end
    end else begin
      hold_d = '0;
      if (found) begin
        cur_d = next_idx;
      end
    end
    // grant vector is registered alongside the owner so outputs never see inputs
    gnt_d        = '0;
    gnt_d[cur_d] = 1'b1;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cur_q     <= '0;
      hold_q    <= '0;
      preempt_q <= 1'b0;
      gnt_q     <= NMASTERS'(1);
    end else begin
      cur_q     <= cur_d;
      hold_q    <= hold_d;
      preempt_q <= preempt_d;
      gnt_q     <= gnt_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_idx = cur_q;
  assign preempt = preempt_q;

endmodule

// File: doc/conbus_arbn.md
CONBUS_ARBN -- requirements
Module: conbus_arbn

Interface
REQ-001 Parameter NMASTERS, default 6, SHALL set the number of requesting masters; legal range is 2..16.
REQ-002 Parameter MAXHOLD, default 0, SHALL set the maximum consecutive requested-grant cycles before forced rotation; 0 means unlimited; legal range is 0..255.
REQ-003 Derived constant IDXW SHALL equal clog2(NMASTERS).
REQ-004 sys_clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 sys_rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 req  input  NMASTERS  SHALL carry per-master bus requests, level-sensitive.
REQ-007 lock  input  NMASTERS  SHALL carry per-master no-preempt requests; only lock[current owner] has effect.
REQ-008 gnt  output  NMASTERS  SHALL carry the one-hot grant, registered.
REQ-009 gnt_idx  output  IDXW  SHALL carry the binary index of the granted master, registered.
REQ-010 preempt  output  1  SHALL be a registered one-cycle pulse that marks a forced rotation.

Function
REQ-011 gnt SHALL be exactly one-hot in every cycle, and gnt_idx SHALL always encode the same master.
REQ-012 Owner cur SHALL keep the grant while req[cur]=1, unless the forced-rotation rule (REQ-015) applies.
REQ-013 When req[cur]=0 and any other req bit is 1, the next owner SHALL be the first requesting index scanning cur+1, cur+2, ..., wrapping modulo NMASTERS.
REQ-014 When req is all zero, the grant SHALL park on cur with no change.
REQ-015 Forced rotation: when MAXHOLD>0, req[cur]=1, lock[cur]=0, hold_cnt=MAXHOLD-1 and any other req bit is 1, the grant SHALL move per the REQ-013 scan and preempt SHALL pulse in the cycle the new grant appears.
REQ-016 hold_cnt SHALL be 0 in the first cycle of a new grant and SHALL increment on each edge where the grant is retained with req[cur]=1, saturating at MAXHOLD-1.
REQ-017 When req[cur]=0, hold_cnt SHALL clear.
REQ-018 A master with lock[cur]=1 SHALL never be preempted, and its hold_cnt SHALL stay saturated.
REQ-019 When lock drops and hold_cnt is already saturated with another request pending, rotation SHALL occur at the next edge.
REQ-020 When the only requester is cur, no preemption SHALL occur regardless of hold_cnt.
REQ-021 Latency: a change in req SHALL be reflected in gnt at the next rising edge, exactly one cycle.
REQ-022 Requests on simultaneous edges SHALL be resolved only by scan order from cur+1; lower index carries no fixed priority.
REQ-023 The design SHALL contain no combinational path from inputs to outputs.

Reset
REQ-024 While sys_rst_n=0, the block SHALL hold gnt=1 (master 0), gnt_idx=0, preempt=0 and hold_cnt=0, asynchronously.
REQ-025 Reset asserted mid-grant SHALL abort ownership immediately; after release, the first evaluation SHALL start from cur=0.
REQ-026 Reset deassertion SHALL take effect on sys_clk; the synchroniser is external.

Structure
REQ-027 NMASTERS/MAXHOLD limits and the IDXW computation SHALL live in the shared conbus package/header.
REQ-028 The rotate-and-find-first logic SHALL be one combinational sub-module, conbus_arbn_pick (inputs: req, cur; outputs: found, next_idx).
REQ-029 The top level SHALL hold only the owner register, hold counter, preempt flag and one-hot decode.

Verification (NMASTERS=6, MAXHOLD=4 unless stated)
REQ-030 Reset release with req=000000 -> gnt=000001, gnt_idx=0 and preempt=0 for 10 cycles.
REQ-031 Owner 5 drops its request with req=000101 -> next gnt=000001 (wrap scan), gnt_idx=0.
REQ-032 req=000011 held constantly from owner 0 -> gnt 000001 for 4 cycles, then 000010 with a preempt pulse, alternating every 4 cycles.
REQ-033 Same stimulus as REQ-032 with lock[0]=1 for 10 cycles -> gnt stays 000001 for 10 cycles; 1 cycle after lock drops, gnt=000010 with preempt=1.
REQ-034 MAXHOLD=0 and req=111111 held -> gnt never leaves 000001; preempt is never asserted.
REQ-035 Reset asserted while owner 3 is active with req=001000 -> gnt=000001 immediately; after release, gnt=001000 one cycle later.
